// File: rtl/d_bridge_wbuf_if.sv
`default_nettype none
// ============================================================================
// Module   : d_bridge_wbuf_if
// Brief    : SRAM-like bus bundle between d_bridge_wbuf (master) and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface d_bridge_wbuf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_addr_ok;
    logic              data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok
    );
endinterface
`default_nettype wire

// File: rtl/d_bridge_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : d_bridge_wbuf
// Brief    : CPU data-SRAM port to SRAM-like bus bridge with a posted-store
//            FIFO; define D_BRIDGE_WBUF_FWD_EN for store-to-load forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module d_bridge_wbuf #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  data_sram_en,
    input  wire [ADDR_W-1:0]     data_sram_addr,
    input  wire [DATA_W/8-1:0]   data_sram_wen,
    input  wire [DATA_W-1:0]     data_sram_wdata,
    output logic [DATA_W-1:0]    data_sram_rdata,
    output logic                 d_stall,
    input  wire                  longest_stall,
    d_bridge_wbuf_if.master      bus
);

    localparam int         c_NB        = DATA_W / 8;
    localparam int         c_LSB       = $clog2(c_NB);
    localparam int         c_PTR_W     = $clog2(WBUF_DEPTH);
    localparam int         c_CNT_W     = c_PTR_W + 1;
    localparam int         c_UA_W      = ADDR_W - c_LSB;
    localparam logic [1:0] c_FULL_SIZE = (DATA_W == 64) ? 2'b11 : 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= 2'b00;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_t              r_state, w_state_nxt;
    logic [c_UA_W-1:0]   r_addr_q [WBUF_DEPTH];
    logic [c_NB-1:0]     r_wen_q  [WBUF_DEPTH];
    logic [DATA_W-1:0]   r_data_q [WBUF_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [DATA_W-1:0]   r_rdata;
    logic [c_UA_W-1:0]   r_rd_addr;

    logic w_is_store, w_is_load, w_full, w_empty, w_push, w_pop;
    logic w_rd_cap, w_fwd_cap, w_rd_launch;
    logic w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic w_unused;

    assign w_unused   = ^data_sram_addr[c_LSB-1:0];
    assign w_is_store = data_sram_en && (|data_sram_wen);
    assign w_is_load  = data_sram_en && !(|data_sram_wen);
    assign w_full     = (r_count == c_CNT_W'(WBUF_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = w_is_store && !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr] <= data_sram_addr[ADDR_W-1:c_LSB];
            r_wen_q[r_wr_ptr]  <= data_sram_wen;
            r_data_q[r_wr_ptr] <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef D_BRIDGE_WBUF_FWD_EN
    // Walk oldest to youngest so the last match seen is the youngest one.
    logic [c_PTR_W-1:0] w_fwd_idx;

    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_fwd_idx  = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            w_fwd_idx = r_rd_ptr + c_PTR_W'(i);
            if ((c_CNT_W'(i) < r_count) &&
                (r_addr_q[w_fwd_idx] == data_sram_addr[ADDR_W-1:c_LSB])) begin
                w_fwd_hit  = &r_wen_q[w_fwd_idx];
                w_fwd_data = r_data_q[w_fwd_idx];
            end
        end
    end
`else
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = '0;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rd_cap    = 1'b0;
        w_fwd_cap   = 1'b0;
        w_rd_launch = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_load && w_fwd_hit) begin
                    w_fwd_cap   = 1'b1;
                    w_state_nxt = DONE;
                end else if (!w_empty) begin
                    w_state_nxt = WR_REQ;
                end else if (w_is_load) begin
                    w_rd_launch = 1'b1;
                    w_state_nxt = RD_REQ;
                end
            end
            WR_REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        w_pop       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WR_WAIT;
                    end
                end
            end
            WR_WAIT: begin
                if (bus.data_data_ok) begin
                    w_pop       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        w_rd_cap    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (bus.data_data_ok) begin
                    w_rd_cap    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!longest_stall) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rdata   <= '0;
            r_rd_addr <= '0;
        end else begin
            if (w_rd_cap)        r_rdata <= bus.data_rdata;
            else if (w_fwd_cap)  r_rdata <= w_fwd_data;
            if (w_rd_launch)     r_rd_addr <= data_sram_addr[ADDR_W-1:c_LSB];
        end
    end

    // Store beats carry the byte offset of the lowest enabled lane.
    logic [c_NB-1:0]   w_head_wen;
    logic [c_LSB-1:0]  w_head_off;
    logic [1:0]        w_head_size;
    logic              w_req, w_wr;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_head_wen = r_wen_q[r_rd_ptr];

    always_comb begin
        w_head_off = '0;
        for (int i = c_NB - 1; i >= 0; i--) begin
            if (w_head_wen[i]) w_head_off = c_LSB'(i);
        end
        case ($countones(w_head_wen))
            1:       w_head_size = 2'b00;
            2:       w_head_size = 2'b01;
            4:       w_head_size = 2'b10;
            8:       w_head_size = 2'b11;
            default: w_head_size = c_FULL_SIZE;
        endcase
    end

    always_comb begin
        w_req   = 1'b0;
        w_wr    = 1'b0;
        w_size  = 2'b00;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            WR_REQ: begin
                w_req   = 1'b1;
                w_wr    = 1'b1;
                w_size  = w_head_size;
                w_addr  = {r_addr_q[r_rd_ptr], w_head_off};
                w_wdata = r_data_q[r_rd_ptr];
            end
            RD_REQ: begin
                w_req  = 1'b1;
                w_size = c_FULL_SIZE;
                w_addr = {r_rd_addr, {c_LSB{1'b0}}};
            end
            default: ;
        endcase
    end

    assign bus.data_req   = w_req;
    assign bus.data_wr    = w_wr;
    assign bus.data_size  = w_size;
    assign bus.data_addr  = w_addr;
    assign bus.data_wdata = w_wdata;

    assign data_sram_rdata = r_rdata;
    assign d_stall = w_rst_n &&
                     ((w_is_load && (r_state != DONE)) || (w_is_store && w_full));

endmodule
`default_nettype wire

// File: tb/tb_d_bridge_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_bridge_wbuf
// Brief    : Randomised self-checking bench for d_bridge_wbuf against a
//            memory/queue reference model and a latency-programmable slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_bridge_wbuf;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int LSB   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] addr;
    logic [NB-1:0] wen;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          d_stall;
    logic          longest_stall;

    d_bridge_wbuf_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    d_bridge_wbuf #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_addr  (addr),
        .data_sram_wen   (wen),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .d_stall         (d_stall),
        .longest_stall   (longest_stall),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: CPU-visible memory, slave memory, expected bus writes.
    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] gmem [logic [AW-1:0]];
    logic [DW-1:0] smem [logic [AW-1:0]];
    wr_t           exp_wq [$];
    int            n_bus_wr = 0;
    int            n_bus_rd = 0;
    int            a_min = 0, a_max = 0, d_min = 0, d_max = 0;

    function automatic logic [DW-1:0] base_val(input logic [AW-1:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [DW-1:0] gval(input logic [AW-1:0] a);
        return gmem.exists(a) ? gmem[a] : base_val(a);
    endfunction

    function automatic logic [DW-1:0] sval(input logic [AW-1:0] a);
        return smem.exists(a) ? smem[a] : base_val(a);
    endfunction

    // Slave: random address-accept and data latencies, 0 meaning same cycle.
    logic          pend_wr;
    logic [AW-1:0] pend_addr, first_addr;
    logic [1:0]    pend_size;
    logic [DW-1:0] pend_data;

    task automatic slave_complete();
        logic [AW-1:0] al;
        logic [DW-1:0] v;
        int            off;
        wr_t           e;
        al = {pend_addr[AW-1:LSB], {LSB{1'b0}}};
        if (pend_wr) begin
            n_bus_wr++;
            chk("wr_expected", 64'(exp_wq.size() > 0), 64'd1);
            if (exp_wq.size() > 0) begin
                e = exp_wq.pop_front();
                chk("wr_addr", pend_addr, e.addr);
                chk("wr_size", pend_size, e.size);
                chk("wr_data", pend_data, e.data);
            end
            v   = sval(al);
            off = int'(pend_addr[LSB-1:0]);
            for (int b = off; b < off + (1 << pend_size) && b < NB; b++)
                v[8*b +: 8] = pend_data[8*b +: 8];
            smem[al] = v;
        end else begin
            n_bus_rd++;
            bus.data_rdata = sval(al);
        end
    endtask

    initial begin : slave
        bit waiting = 0;
        bit pending = 0;
        int wcnt = 0;
        int dcnt = 0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
        forever begin
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            if (!rst) begin
                waiting = 0;
                pending = 0;
            end else if (pending) begin
                chk("one_outstanding", bus.data_req, 1'b0);
                if (dcnt == 0) begin
                    bus.data_data_ok = 1'b1;
                    slave_complete();
                    pending = 0;
                end else begin
                    dcnt--;
                end
            end else if (bus.data_req) begin
                if (!waiting) begin
                    waiting    = 1;
                    wcnt       = $urandom_range(a_max, a_min);
                    first_addr = bus.data_addr;
                end
                if (wcnt == 0) begin
                    waiting   = 0;
                    pend_wr   = bus.data_wr;
                    pend_addr = bus.data_addr;
                    pend_size = bus.data_size;
                    pend_data = bus.data_wdata;
                    chk("req_stable", pend_addr, first_addr);
                    if (!pend_wr) begin
                        chk("rd_after_drain", exp_wq.size(), 0);
                        chk("rd_size", pend_size, 2'b10);
                    end
                    bus.data_addr_ok = 1'b1;
                    dcnt = $urandom_range(d_max, d_min);
                    if (dcnt == 0) begin
                        bus.data_data_ok = 1'b1;
                        slave_complete();
                    end else begin
                        pending = 1;
                        dcnt--;
                    end
                end else begin
                    wcnt--;
                end
            end
        end
    end

    task automatic set_lat(input int amin, input int amax, input int dmin, input int dmax);
        a_min = amin; a_max = amax; d_min = dmin; d_max = dmax;
    endtask

    task automatic cpu_idle(input int n);
        en  = 1'b0;
        wen = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_store(input logic [AW-1:0] a, input logic [NB-1:0] w,
                             input logic [DW-1:0] d, output bit stalled);
        wr_t           e;
        logic [DW-1:0] v;
        bit            acc;
        en = 1'b1; addr = a; wen = w; wdata = d;
        stalled = 0;
        acc     = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!d_stall) begin
                acc = 1;
                break;
            end
            stalled = 1;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("store_timeout", d_stall, 1'b0);
        e.addr = a;
        e.addr[LSB-1:0] = '0;
        for (int b = NB - 1; b >= 0; b--) if (w[b]) e.addr[LSB-1:0] = LSB'(b);
        case ($countones(w))
            1:       e.size = 2'd0;
            2:       e.size = 2'd1;
            4:       e.size = 2'd2;
            default: e.size = 2'd3;
        endcase
        e.data = d;
        exp_wq.push_back(e);
        v = gval(a);
        for (int b = 0; b < NB; b++) if (w[b]) v[8*b +: 8] = d[8*b +: 8];
        gmem[a] = v;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_load(input logic [AW-1:0] a, input int hold, output int stall_cyc);
        logic [DW-1:0] exp;
        bit            done;
        en = 1'b1; addr = a; wen = '0;
        exp       = gval(a);
        stall_cyc = 0;
        done      = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!d_stall) begin
                done = 1;
                break;
            end
            stall_cyc++;
            @(posedge clk);
            #1;
        end
        if (!done) chk("load_timeout", d_stall, 1'b0);
        chk("load_data", rdata, exp);
        for (int h = 0; h < hold; h++) begin
            longest_stall = 1'b1;
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("hold_rdata", rdata, exp);
            chk("hold_no_req", bus.data_req, 1'b0);
            chk("hold_no_stall", d_stall, 1'b0);
        end
        longest_stall = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 1000 && exp_wq.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", exp_wq.size(), 0);
        chk("drain_bus_idle", bus.data_req, 1'b0);
    endtask

    task automatic random_ops(input int n);
        logic [NB-1:0] wl [8];
        bit            st;
        int            sc, r;
        logic [AW-1:0] a;
        wl[0] = 4'hF; wl[1] = 4'hF; wl[2] = 4'h3; wl[3] = 4'hC;
        wl[4] = 4'h1; wl[5] = 4'h2; wl[6] = 4'h4; wl[7] = 4'h8;
        for (int i = 0; i < n; i++) begin
            set_lat(0, $urandom_range(3, 0), 0, $urandom_range(3, 0));
            r = $urandom_range(99, 0);
            a = 32'h800 + (32'($urandom_range(7, 0)) << LSB);
            if (r < 55)      cpu_store(a, wl[$urandom_range(7, 0)], $urandom, st);
            else if (r < 90) cpu_load(a, $urandom_range(2, 0), sc);
            else             cpu_idle($urandom_range(3, 1));
        end
        cpu_idle(1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit st;
        int sc, rd0, wr0;
        rst = 1'b0; en = 1'b0; addr = '0; wen = '0; wdata = '0;
        longest_stall = 1'b0;
        set_lat(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        #1;
        chk("rst_d_stall", d_stall, 1'b0);
        chk("rst_rdata", rdata, '0);
        chk("rst_req", bus.data_req, 1'b0);
        chk("rst_wr", bus.data_wr, 1'b0);
        chk("rst_addr", bus.data_addr, '0);
        chk("rst_wdata", bus.data_wdata, '0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single store, ideal slave
        wr0 = n_bus_wr;
        cpu_store(32'h100, 4'hF, 32'h1122_3344, st);
        chk("s1_no_stall", st, 1'b0);
        cpu_idle(1);
        wait_drain();
        chk("s1_one_write", n_bus_wr - wr0, 1);

        // Five back-to-back stores against a slow address phase
        set_lat(3, 3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cpu_store(32'h400 + 32'(i * 4), 4'hF, $urandom, st);
            chk($sformatf("s5_stall_%0d", i), st, (i == 4));
        end
        cpu_idle(1);
        wait_drain();

        // Load with addr_ok and data_ok together
        set_lat(0, 0, 0, 0);
        smem[32'h200] = 32'hCAFE_F00D;
        gmem[32'h200] = 32'hCAFE_F00D;
        cpu_load(32'h200, 0, sc);
        chk("ld_stall_cycles", sc, 2);
        cpu_idle(1);

        // Load finishing under a global stall
        set_lat(1, 1, 2, 2);
        rd0 = n_bus_rd;
        longest_stall = 1'b1;
        cpu_load(32'h204, 5, sc);
        chk("ls_one_read", n_bus_rd - rd0, 1);
        cpu_idle(1);
        chk("ls_idle_req", bus.data_req, 1'b0);

        // Store then load to the same word
        set_lat(0, 0, 0, 0);
        rd0 = n_bus_rd;
        wr0 = n_bus_wr;
        cpu_store(32'h300, 4'hF, 32'hDEAD_BEEF, st);
        cpu_load(32'h300, 0, sc);
`ifdef D_BRIDGE_WBUF_FWD_EN
        chk("fwd_no_bus_read", n_bus_rd - rd0, 0);
        chk("fwd_stall_cycles", sc, 1);
`else
        chk("nofwd_bus_read", n_bus_rd - rd0, 1);
        chk("nofwd_write_first", n_bus_wr - wr0, 1);
`endif
        cpu_idle(1);
        wait_drain();

        random_ops(200);
        wait_drain();

        // Reset while a read is outstanding
        set_lat(0, 0, 20, 20);
        en = 1'b1; addr = 32'h208; wen = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("rdwait_stall", d_stall, 1'b1);
        chk("rdwait_no_req", bus.data_req, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_d_stall", d_stall, 1'b0);
        chk("arst_req", bus.data_req, 1'b0);
        chk("arst_wr", bus.data_wr, 1'b0);
        chk("arst_addr", bus.data_addr, '0);
        chk("arst_wdata", bus.data_wdata, '0);
        chk("arst_rdata", rdata, '0);
        exp_wq.delete();
        gmem = smem;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        set_lat(0, 0, 0, 0);
        cpu_load(32'h208, 0, sc);
        random_ops(40);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/d_bridge_wbuf.md
D_BRIDGE_WBUF -- requirements
Module: d_bridge_wbuf

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; legal values are 32 and 64.
REQ-003 SHALL have parameter WBUF_DEPTH, default 4: write-buffer entries; power of two, at least 2.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 data_sram_en  in  1  CPU access valid.
REQ-007 data_sram_addr  in  ADDR_W  CPU address.
REQ-008 data_sram_wen  in  DATA_W/8  byte write enables; zero means a read.
REQ-009 data_sram_wdata  in  DATA_W  CPU store data.
REQ-010 data_sram_rdata  out  DATA_W  load result.
REQ-011 d_stall  out  1  pipeline stall request.
REQ-012 longest_stall  in  1  global stall; the load result is held while it is high.
REQ-013 data_req / data_wr  out  1 each  SRAM-like request and write flag.
REQ-014 data_size  out  2  00 byte, 01 half, 10 word, 11 doubleword (DATA_W=64 only).
REQ-015 data_addr / data_wdata  out  ADDR_W / DATA_W  SRAM-like address and write data.
REQ-016 data_rdata  in  DATA_W; data_addr_ok, data_data_ok  in  1 each  SRAM-like responses.

Function
REQ-017 Stores SHALL be posted into a FIFO write buffer (address, wen, data) in the cycle presented when the buffer is not full; d_stall SHALL be 0 for that cycle.
REQ-018 A store presented while the buffer is full SHALL raise d_stall until a slot frees; the store SHALL then enqueue in the cycle d_stall drops.
REQ-019 The bus FSM states SHALL be IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT and DONE; at most one bus transaction is outstanding.
REQ-020 IDLE -> WR_REQ when the buffer is non-empty; the buffer drains in FIFO order and has priority over loads.
REQ-021 IDLE -> RD_REQ when the buffer is empty and a load is pending.
REQ-022 In WR_REQ and RD_REQ the block SHALL hold data_req=1 with stable outputs until data_addr_ok, then move to the matching *_WAIT state.
REQ-023 If data_addr_ok and data_data_ok arrive in the same cycle, both SHALL be consumed and the *_WAIT state skipped.
REQ-024 On data_data_ok in WR_WAIT the head entry SHALL pop and the FSM SHALL return to IDLE.
REQ-025 On data_data_ok in RD_WAIT, data_rdata SHALL be registered into data_sram_rdata and the FSM SHALL enter DONE.
REQ-026 DONE SHALL hold while longest_stall=1 and return to IDLE when longest_stall=0.
REQ-027 d_stall for a load SHALL be 1 from presentation until DONE is reached; in DONE d_stall=0.
REQ-028 data_size SHALL be derived from the popcount and alignment of wen: 1 byte -> 00, 2 -> 01, 4 -> 10, 8 -> 11; loads use the full width (10 or 11).
REQ-029 A simultaneous enqueue and pop SHALL leave the count unchanged; pointers wrap modulo WBUF_DEPTH.
REQ-030 Load ordering relative to buffered stores is governed by REQ-037 and REQ-038.

Reset
REQ-031 Asserting rst SHALL immediately force: FSM to IDLE, buffer pointers and count to 0, data_sram_rdata to 0, data_req to 0.
REQ-032 Asserting rst SHALL immediately force: d_stall, data_wr, data_addr and data_wdata to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction and discard buffered stores.
REQ-034 Release of rst SHALL be synchronised so the first active edge sees a clean IDLE state.

Configuration
REQ-035 Store-to-load forwarding SHALL be controlled by the macro D_BRIDGE_WBUF_FWD_EN.
REQ-036 With D_BRIDGE_WBUF_FWD_EN defined, a forwarding hit SHALL occur when a load matches the address of a buffered entry at full-width alignment and the youngest matching entry has all wen bits set.
REQ-037 On a forwarding hit the load SHALL return that entry's data in DONE on the next cycle without a bus transaction; a partial-wen match SHALL fall back to REQ-038.
REQ-038 Without the macro, a load SHALL wait until the buffer is empty and then issue on the bus.

Verification
REQ-039 Store A=0x100, wen=0xF, D=0x11223344 with an ideal slave -> no stall; one bus write with size 10, data_wdata=0x11223344.
REQ-040 Five back-to-back stores with WBUF_DEPTH=4 and addr_ok delayed 3 cycles -> d_stall=1 on the fifth store only; bus writes issued in order.
REQ-041 Load 0x200 with addr_ok and data_ok in the same cycle, returning 0xCAFEF00D -> data_sram_rdata=0xCAFEF00D; d_stall drops the next cycle.
REQ-042 Load completes while longest_stall=1 for 5 cycles -> rdata held, no new data_req, back to IDLE after release.
REQ-043 Store 0x300/0xDEADBEEF, then load 0x300 -> with the macro, returns 0xDEADBEEF with no bus read; without it, the bus write precedes the bus read.
REQ-044 rst asserted during RD_WAIT -> all outputs are 0 within the same cycle; normal operation resumes after release.
